// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and the
// baud divider calculation used by both the receiver and the transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Clocks per oversample tick, truncated. Values below 2 are not supported.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the wrap.
// While clear is high the counter is parked at 0 so the first tick after
// clear drops lands exactly DIV clocks later.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 24000000,
  parameter int BAUD   = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign tick   = w_wrap && !clear;

  // Divider counter, held at zero while cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/simple_uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, 16x oversampling.
// Start edge is taken from the synchronized line; the start bit is
// re-checked at its middle to reject glitches, data and stop bits are
// sampled at their middles. A low stop bit raises frame_err and the
// receiver then waits in BREAK until the line returns high.
module simple_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 24000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  uart_state_e r_state, w_next;

  logic       r_sync1, r_rx_s, r_rx_d;
  logic [3:0] r_os;
  logic [2:0] r_bitn;
  logic [7:0] r_sh, r_data;
  logic       r_valid, r_frame_err;

  logic w_tick, w_clear, w_start_det, w_mid_start, w_mid_bit;
  logic w_busy;

  uart_baud_tick #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(w_clear),
    .tick (w_tick)
  );

  // Two-flop synchronizer plus one delay flop for edge detection; reset
  // to 1 so a line held low through reset still yields a falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= line;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_start_det) w_next = START;
      START: if (w_mid_start) w_next = r_rx_s ? IDLE : DATA;
      DATA:  if (w_mid_bit && r_bitn == 3'd7) w_next = STOP;
      STOP:  if (w_mid_bit) w_next = r_rx_s ? IDLE : BREAK;
      BREAK: if (r_rx_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Decoded control: sample points, tick-counter hold and busy flag
  always_comb begin
    w_start_det = (r_state == IDLE) && r_rx_d && !r_rx_s;
    w_clear     = (r_state == IDLE);
    w_mid_start = (r_state == START) && w_tick && (r_os == 4'd7);
    w_mid_bit   = w_tick && (r_os == 4'd15);
    w_busy      = (r_state != IDLE);
  end

  // Sub-tick and bit counters; os is re-zeroed mid start bit so later
  // samples land at os==15, one full bit apart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os   <= '0;
      r_bitn <= '0;
    end else begin
      if (w_start_det || w_mid_start) r_os <= '0;
      else if (w_tick)                r_os <= r_os + 4'd1;
      if (w_mid_start)                          r_bitn <= '0;
      else if (r_state == DATA && w_mid_bit)    r_bitn <= r_bitn + 3'd1;
    end
  end

  // Shift register (LSB arrives first, enters at MSB) and output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh        <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state == DATA && w_mid_bit) r_sh <= {r_rx_s, r_sh[7:1]};
      if (r_state == STOP && w_mid_bit) begin
        if (r_rx_s) begin
          r_data  <= r_sh;
          r_valid <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = w_busy;

endmodule

// File: doc/simple_uart_rx.md
# simple_uart_rx

Asynchronous serial receiver, 8N1, LSB first, idle-high line. It samples the `line` input from a board pin with 16x oversampling derived from the system clock. Each valid byte is presented on `data` with a one-cycle `valid` strobe. It is the receive-side counterpart of the team's UART transmitter: board-level loopback and host-to-FPGA command input.

## Interface
- `CLK_HZ`, 24000000: system clock frequency in Hz.
- `BAUD`, 115200: line bit rate.
- Derived constant: `DIV = CLK_HZ / (BAUD*16)`, integer, truncated; 13 at defaults (actual rate 115384 baud, +0.16 %). `DIV` < 2 is a configuration error.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `line`  in  1  serial input, asynchronous to `clk`, idle high.
- `data`  out  8  last correctly framed byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse; `data` is new in the same cycle.
- `frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- `line` passes through a 2-flop synchronizer to give `rx_s`. Reset value of both flops is 1.
- Tick generator: a counter 0..DIV-1 pulses `tick` for one cycle on wrap. It is held at 0 in IDLE and restarts on start detection.
- A 4-bit sub-tick counter `os` counts ticks within a bit. A 3-bit `bitn` counts data bits. An 8-bit shift register `sh` shifts right, with the new bit entering at MSB.
- State machine:
  - IDLE: on `rx_s` 1→0, clear `os`, go to START.
  - START: at `os`==7 (mid start bit), sample `rx_s`. If 1, treat it as a glitch and go to IDLE with no output. If 0, clear `os` and `bitn` and go to DATA.
  - DATA: at `os`==15 (mid-bit), shift `rx_s` into `sh`. When `bitn`==7 at that point, go to STOP; otherwise increment `bitn`.
  - STOP: at `os`==15, sample `rx_s`. If 1, `data`←`sh`, pulse `valid`, go to IDLE. If 0, pulse `frame_err`, leave `data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. No further strobes are issued while the line stays low.
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, all counters 0, `sh`=0.
- Reset asserted mid-frame clears everything immediately. The partial byte is discarded. After release, the receiver resynchronizes on the next 1→0 edge. If the line is low at release, the synchronizer's reset value of 1 causes a falling edge to be detected. A spurious frame may then result, caught by START-glitch or STOP checks.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Start detection occurs 2–3 clocks after the falling edge of `line` (synchronizer).
- Mid-start sample falls 8·DIV clocks after detection. Each data sample follows at 16·DIV-clock spacing. The stop sample comes 9·16·DIV clocks after the mid-start sample.
- `valid` latency from the `line` falling edge is (8 + 9·16)·DIV + 2..3 clocks = 1978..1979 clocks at defaults (≈9.5 bit times).
- The receiver returns to IDLE at mid-stop. A start edge that begins right at the end of the stop bit is accepted, so back-to-back frames need no idle gap.
- Tolerated baud mismatch is ≥ ±3 % (sample drift < half bit over 9.5 bits).

## Structure
- Shared package/include `uart_pkg`:
  - state encoding: IDLE, START, DATA, STOP, BREAK, 3-bit;
  - `OVERSAMPLE`=16;
  - `DIV` computation function, reused by the transmitter.
- Sub-module `uart_baud_tick` (params `CLK_HZ`, `BAUD`; ports `clk`, `rst_n`, `clear`, `tick`). Shared with future TX rework.
- Receiver core: synchronizer, FSM, shift register, output registers.

## Test plan
- Send 0x55 at 115200 → `valid` pulses once, 1978±1 clocks after the start edge, with `data`=0x55, `frame_err`=0, and `busy` low afterward.
- Send 0x00 then 0xFF back-to-back with no idle → two `valid` pulses, `data` 0x00 then 0xFF, no `frame_err`.
- Low glitch of 5·DIV clocks on idle line → `busy` pulses high and falls about 8·DIV clocks after detection; no `valid`, no `frame_err`, `data` unchanged.
- Frame 0xA5 with stop bit forced 0 and line held low 3 bit times → one `frame_err` pulse, no `valid`, `data` keeps the previous value, state stays BREAK until the line is high, then 0x3C is received correctly.
- Assert `rst_n` low for 3 clocks during bit 4 of a frame → outputs and state reset immediately. The next clean frame 0x81 yields `data`=0x81.
- Stream 0x00..0xFF continuously at +3 % and −3 % baud → 256 `valid` pulses, bytes received in order, zero `frame_err`.
